// File: rtl/tc_pkg.sv
// ---------------------------------------------------------------------------
// tc_pkg
// Shared definitions for timer_counter: FSM state encoding, register word
// offsets (Addr[3:2]), CTRL bit positions and mode codes.
// ---------------------------------------------------------------------------
package tc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tc_state_e;

    // Word offsets decoded from Addr[3:2]
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    // CTRL register layout
    localparam int CTRL_W       = 4;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    // Mode codes; 2'b1x decodes as one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/timer_counter.sv
// ---------------------------------------------------------------------------
// timer_counter
// Memory-mapped 32-bit down-counting timer with level interrupt.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   Addr     in   byte address, only Addr[3:2] decoded
//   WE       in   word write enable
//   Din      in   write data
//   Dout     out  read data, combinational from registers
//   IRQ      out  interrupt request (CTRL.IM & irq_flag)
//
// Register map (Addr[3:2]): 0 CTRL, 1 PRESET, 2 COUNT (RO), 3 reserved (RAZ/WI)
//
// Configuration macro: TC_AUTORELOAD_EN
//   defined   - mode 01 reloads from PRESET after each interrupt
//   undefined - every mode behaves as one-shot
// ---------------------------------------------------------------------------
module timer_counter
    import tc_pkg::*;
#(
    parameter logic [31:0] RESET_PRESET = 32'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    tc_state_e          r_state, w_state_nxt;
    logic [CTRL_W-1:0]  r_ctrl,  w_ctrl_nxt;
    logic [31:0]        r_preset;
    logic [31:0]        r_count, w_count_nxt;
    logic               r_flag,  w_flag_nxt;

    logic [1:0]         w_off;
    logic               w_wr_ctrl;
    logic               w_wr_pre;
    logic               w_en_cnt;
    logic               w_unused;

    assign w_off     = Addr[3:2];
    assign w_wr_ctrl = WE && (w_off == OFF_CTRL);
    assign w_wr_pre  = WE && (w_off == OFF_PRESET);
    assign w_unused  = ^{Addr[31:4], Addr[1:0]};

    // A disabling CTRL write freezes COUNT at the value visible during the
    // write cycle, so the counting state looks at the incoming Enable bit.
    assign w_en_cnt  = w_wr_ctrl ? Din[CTRL_EN] : r_ctrl[CTRL_EN];

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_ctrl   <= '0;
            r_preset <= RESET_PRESET;
            r_count  <= '0;
            r_flag   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ctrl   <= w_ctrl_nxt;
            r_count  <= w_count_nxt;
            r_flag   <= w_flag_nxt;
            if (w_wr_pre)
                r_preset <= Din;
        end
    end

    // ---------------- next state / datapath ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        // Any CTRL write clears a held interrupt; FSM actions below override.
        w_ctrl_nxt  = w_wr_ctrl ? Din[CTRL_W-1:0] : r_ctrl;
        w_flag_nxt  = w_wr_ctrl ? 1'b0 : r_flag;

        unique case (r_state)
            ST_IDLE: begin
                if (r_ctrl[CTRL_EN])
                    w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_count_nxt = r_preset;
                w_state_nxt = ST_CNT;
            end
            ST_CNT: begin
                if (!w_en_cnt) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_count <= 32'd1) begin
                    // PRESET of 0 or 1 both expire after a single CNT cycle
                    w_count_nxt = '0;
                    w_flag_nxt  = 1'b1;
                    w_state_nxt = ST_INT;
                end else begin
                    w_count_nxt = r_count - 32'd1;
                end
            end
            ST_INT: begin
`ifdef TC_AUTORELOAD_EN
                if (r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD) begin
                    w_flag_nxt  = 1'b0;
                    w_state_nxt = ST_LOAD;
                end else begin
                    // A simultaneous bus write to CTRL takes precedence
                    if (!w_wr_ctrl)
                        w_ctrl_nxt[CTRL_EN] = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
`else
                if (!w_wr_ctrl)
                    w_ctrl_nxt[CTRL_EN] = 1'b0;
                w_state_nxt = ST_IDLE;
`endif
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- read mux / outputs ----------------
    always_comb begin
        Dout = '0;
        unique case (w_off)
            OFF_CTRL:   Dout = {{(32-CTRL_W){1'b0}}, r_ctrl};
            OFF_PRESET: Dout = r_preset;
            OFF_COUNT:  Dout = r_count;
            default:    Dout = '0;
        endcase
    end

    assign IRQ = r_ctrl[CTRL_IM] & r_flag;

endmodule
